// File: rtl/leaf_relay_pkg.sv
// Shared field widths, route-table entry type and constants for the leaf_relay BFT endpoint.
package leaf_relay_pkg;

    localparam int unsigned DEF_PAYLOAD_BITS  = 32;
    localparam int unsigned DEF_NUM_ADDR_BITS = 7;
    localparam int unsigned DEF_NUM_PORT_BITS = 4;
    localparam int unsigned DEF_NUM_LEAF_BITS = 5;
    localparam int unsigned DEF_PACKET_BITS   = 1 + DEF_NUM_LEAF_BITS + DEF_NUM_PORT_BITS
                                                  + DEF_NUM_ADDR_BITS + DEF_PAYLOAD_BITS;

    // Config payload layout: {enable[9], dest_leaf[8:4], dest_port[3:0]}
    localparam int unsigned CFG_DEST_PORT_LSB  = 0;
    localparam int unsigned CFG_DEST_PORT_BITS = 4;
    localparam int unsigned CFG_DEST_LEAF_LSB  = 4;
    localparam int unsigned CFG_DEST_LEAF_BITS = 5;
    localparam int unsigned CFG_ENABLE_BIT     = 9;

    localparam int unsigned CFG_PORT = 0;

    typedef struct packed {
        logic                          enable;
        logic [CFG_DEST_LEAF_BITS-1:0] dest_leaf;
        logic [CFG_DEST_PORT_BITS-1:0] dest_port;
    } route_entry_t;

endpackage

// File: rtl/leaf_relay_fifo.sv
// Synchronous FIFO; a full FIFO refuses a push even when a pop happens in the same cycle.
module leaf_relay_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata_c,
    output logic                     o_full,
    output logic                     o_empty_c,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push && !r_full;
    assign w_pop_ok  = i_pop && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
        end
    end

    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty_c = (r_count == '0);
    assign o_count   = r_count;

endmodule

// File: rtl/leaf_relay.sv
// BFT leaf endpoint: buffers data packets addressed to this leaf and re-emits them to a configured route.
// Optional fwd_count statistics output is enabled by defining LEAF_RELAY_STATS_EN.
module leaf_relay
    import leaf_relay_pkg::*;
#(
    parameter int unsigned PACKET_BITS   = DEF_PACKET_BITS,
    parameter int unsigned PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
    parameter int unsigned NUM_LEAF_BITS = DEF_NUM_LEAF_BITS,
    parameter int unsigned NUM_PORT_BITS = DEF_NUM_PORT_BITS,
    parameter int unsigned NUM_ADDR_BITS = DEF_NUM_ADDR_BITS,
    parameter int unsigned NUM_IN_PORTS  = 2,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned SELF_LEAF     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PACKET_BITS-1:0] din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0] dout_leaf_interface2bft,
    input  logic                   resend,
    output logic [15:0]            drop_count,
    output logic                   fifo_full
`ifdef LEAF_RELAY_STATS_EN
    ,
    output logic [15:0]            fwd_count
`endif
);

    localparam int unsigned ADDR_LSB  = PAYLOAD_BITS;
    localparam int unsigned PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
    localparam int unsigned LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
    localparam int unsigned VALID_BIT = LEAF_LSB + NUM_LEAF_BITS;
    localparam int unsigned FIFO_W    = NUM_PORT_BITS + PAYLOAD_BITS;
    localparam int unsigned IDX_W     = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;
    localparam int unsigned ROUTES    = 1 << IDX_W;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

    route_entry_t             r_route [ROUTES];
    logic [NUM_ADDR_BITS-1:0] r_seq   [ROUTES];
    logic [PACKET_BITS-1:0]   r_dout;
    logic [PACKET_BITS-1:0]   r_last;
    logic [15:0]              r_drop;

    logic                     w_valid;
    logic [NUM_LEAF_BITS-1:0] w_leaf;
    logic [NUM_PORT_BITS-1:0] w_port;
    logic [NUM_ADDR_BITS-1:0] w_addr;
    logic [PAYLOAD_BITS-1:0]  w_payload;
    logic                     w_hit;
    logic                     w_is_cfg;
    logic                     w_cfg_ok;
    logic                     w_data_ok;
    logic [IDX_W-1:0]         w_cfg_idx;
    logic [IDX_W-1:0]         w_data_idx;
    logic                     w_cfg_wr;
    logic                     w_push;
    logic                     w_drop;

    logic                     w_pop;
    logic [FIFO_W-1:0]        w_head;
    logic [NUM_PORT_BITS-1:0] w_head_port;
    logic [IDX_W-1:0]         w_head_idx;
    route_entry_t             w_head_route;
    logic [PACKET_BITS-1:0]   w_emit;
    logic                     w_full;
    logic                     w_empty;
    logic [CNT_W-1:0]         w_count;

    // Input packet decode and accept/drop classification.
    assign w_valid    = din_leaf_bft2interface[VALID_BIT];
    assign w_leaf     = din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS];
    assign w_port     = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
    assign w_addr     = din_leaf_bft2interface[ADDR_LSB +: NUM_ADDR_BITS];
    assign w_payload  = din_leaf_bft2interface[0 +: PAYLOAD_BITS];

    assign w_hit      = w_valid && (w_leaf == NUM_LEAF_BITS'(SELF_LEAF));
    assign w_is_cfg   = (w_port == NUM_PORT_BITS'(CFG_PORT));
    assign w_cfg_ok   = (w_addr != '0) && (w_addr <= NUM_ADDR_BITS'(NUM_IN_PORTS));
    assign w_data_ok  = !w_is_cfg && (w_port <= NUM_PORT_BITS'(NUM_IN_PORTS));
    assign w_cfg_idx  = IDX_W'(w_addr - NUM_ADDR_BITS'(1));
    assign w_data_idx = IDX_W'(w_port - NUM_PORT_BITS'(1));

    assign w_cfg_wr   = w_hit && w_is_cfg && w_cfg_ok;
    assign w_push     = w_hit && w_data_ok && r_route[w_data_idx].enable
                        && (w_count != CNT_W'(FIFO_DEPTH));
    assign w_drop     = w_hit && !w_cfg_wr && !w_push;

    // Route lookup happens at pop time, so reconfiguration applies to queued packets.
    assign w_pop        = !resend && !w_empty;
    assign w_head_port  = w_head[PAYLOAD_BITS +: NUM_PORT_BITS];
    assign w_head_idx   = IDX_W'(w_head_port - NUM_PORT_BITS'(1));
    assign w_head_route = r_route[w_head_idx];
    assign w_emit       = PACKET_BITS'({1'b1,
                                        NUM_LEAF_BITS'(w_head_route.dest_leaf),
                                        NUM_PORT_BITS'(w_head_route.dest_port),
                                        r_seq[w_head_idx],
                                        w_head[0 +: PAYLOAD_BITS]});

    leaf_relay_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_data    ({w_port, w_payload}),
        .i_pop     (w_pop),
        .o_rdata_c (w_head),
        .o_full    (w_full),
        .o_empty_c (w_empty),
        .o_count   (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROUTES; i++) begin
                r_route[i] <= '0;
            end
        end else if (w_cfg_wr) begin
            r_route[w_cfg_idx] <= '{enable:    w_payload[CFG_ENABLE_BIT],
                                    dest_leaf: w_payload[CFG_DEST_LEAF_LSB +: CFG_DEST_LEAF_BITS],
                                    dest_port: w_payload[CFG_DEST_PORT_LSB +: CFG_DEST_PORT_BITS]};
        end
    end

    // Output register: resend beats a FIFO pop, which beats idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= '0;
            r_last <= '0;
            for (int i = 0; i < ROUTES; i++) begin
                r_seq[i] <= '0;
            end
        end else if (resend) begin
            r_dout <= r_last;
        end else if (!w_empty) begin
            r_dout             <= w_emit;
            r_last             <= w_emit;
            r_seq[w_head_idx]  <= r_seq[w_head_idx] + NUM_ADDR_BITS'(1);
        end else begin
            r_dout <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
        end
    end

`ifdef LEAF_RELAY_STATS_EN
    logic [15:0] r_fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd <= '0;
        end else if (w_pop) begin
            r_fwd <= r_fwd + 16'd1;
        end
    end

    assign fwd_count = r_fwd;
`endif

    assign dout_leaf_interface2bft = r_dout;
    assign drop_count              = r_drop;
    assign fifo_full               = w_full;

endmodule

// File: tb/tb_leaf_relay.sv
// Bench for leaf_relay: queue-based reference model checked every cycle, plus directed literal checks.
module tb_leaf_relay;

    logic        clk = 1'b0;
    logic        reset;
    logic        resend;
    logic [48:0] din;
    logic [48:0] dout;
    logic [15:0] drop_count;
    logic        fifo_full;
`ifdef LEAF_RELAY_STATS_EN
    logic [15:0] fwd_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    leaf_relay dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_bft2interface  (din),
        .dout_leaf_interface2bft (dout),
        .resend                  (resend),
        .drop_count              (drop_count),
        .fifo_full               (fifo_full)
`ifdef LEAF_RELAY_STATS_EN
        ,
        .fwd_count               (fwd_count)
`endif
    );

    // Reference model: a queue of {port, payload} plus route/sequence tables.
    logic [35:0] m_q[$];
    bit          m_en [16];
    logic [4:0]  m_dl [16];
    logic [3:0]  m_dp [16];
    int          m_seq[16];
    logic [48:0] m_last;
    logic [48:0] m_dout;
    int          m_drop;
    int          m_fwd;
    bit          m_init = 1'b0;
    bit          m_was_full;
    logic [35:0] m_e;
    int          m_p;
    int          m_a;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            for (int i = 0; i < 16; i++) begin
                m_en[i] = 1'b0; m_dl[i] = '0; m_dp[i] = '0; m_seq[i] = 0;
            end
            m_last = '0; m_dout = '0; m_drop = 0; m_fwd = 0; m_init = 1'b1;
        end else begin
            m_was_full = (m_q.size() == 16);
            if (resend) begin
                m_dout = m_last;
            end else if (m_q.size() > 0) begin
                m_e    = m_q.pop_front();
                m_p    = int'(m_e[35:32]);
                m_dout = {1'b1, m_dl[m_p], m_dp[m_p], 7'(m_seq[m_p]), m_e[31:0]};
                m_last = m_dout;
                m_seq[m_p] = (m_seq[m_p] + 1) % 128;
                m_fwd  = (m_fwd + 1) % 65536;
            end else begin
                m_dout = '0;
            end
            if (din[48] && din[47:43] == 5'd3) begin
                m_p = int'(din[42:39]);
                m_a = int'(din[38:32]);
                if (m_p == 0) begin
                    if (m_a >= 1 && m_a <= 2) begin
                        m_en[m_a] = din[9]; m_dl[m_a] = din[8:4]; m_dp[m_a] = din[3:0];
                    end else if (m_drop < 65535) begin
                        m_drop++;
                    end
                end else if (m_p <= 2 && m_en[m_p] && !m_was_full) begin
                    m_q.push_back({din[42:39], din[31:0]});
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [48:0] act, input logic [48:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("dout", dout, m_dout);
            chk("drop_count", 49'(drop_count), 49'(m_drop[15:0]));
            chk("fifo_full", 49'(fifo_full), 49'(m_q.size() == 16));
`ifdef LEAF_RELAY_STATS_EN
            chk("fwd_count", 49'(fwd_count), 49'(m_fwd[15:0]));
`endif
        end
    end

    // Drive values that the next rising edge samples.
    task automatic tick(input logic [48:0] pkt, input logic rs, input logic rst);
        @(posedge clk);
        #1;
        din = pkt; resend = rs; reset = rst;
    endtask

    function automatic logic [48:0] mk(input int leaf, input int port, input int addr,
                                       input logic [31:0] pl);
        return {1'b1, 5'(leaf), 4'(port), 7'(addr), pl};
    endfunction

    logic [48:0] rp;

    initial begin
        reset = 1'b1; din = '0; resend = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dout", dout, 49'd0);
        chk("reset_drop", 49'(drop_count), 49'd0);
        chk("reset_full", 49'(fifo_full), 49'd0);
        tick('0, 0, 0);

        // Unconfigured route drops; foreign leaf is ignored.
        tick(mk(3, 2, 0, 32'h1111_1111), 0, 0);
        tick(mk(4, 1, 0, 32'h2222_2222), 0, 0);
        tick('0, 0, 0);
        @(negedge clk);
        chk("drop_unconfigured", 49'(drop_count), 49'd1);

        // Route port1 -> leaf 7, port 2, enabled; two packets get seq 0 then 1.
        tick(mk(3, 0, 1, 32'h0000_0272), 0, 0);
        tick(mk(3, 1, 0, 32'hDEAD_BEEF), 0, 0);
        tick(mk(3, 1, 0, 32'h1234_5678), 0, 0);
        tick('0, 0, 0);
        @(negedge clk);
        chk("first_emit", dout, {1'b1, 5'd7, 4'd2, 7'd0, 32'hDEAD_BEEF});
        tick('0, 0, 0);
        @(negedge clk);
        chk("second_emit", dout, {1'b1, 5'd7, 4'd2, 7'd1, 32'h1234_5678});

        // Fill while stalled by resend, overflow, then release.
        for (int i = 0; i < 16; i++) tick(mk(3, 1, 0, 32'hA000_0000 + i), 1, 0);
        tick(mk(3, 1, 0, 32'hBAD0_0017), 1, 0);
        @(negedge clk);
        chk("fifo_full_set", 49'(fifo_full), 49'd1);
        tick(mk(3, 1, 0, 32'hBAD0_0018), 0, 0);
        tick('0, 0, 0);
        @(negedge clk);
        chk("drop_after_full", 49'(drop_count), 49'd3);
        chk("drain_head", dout, {1'b1, 5'd7, 4'd2, 7'd2, 32'hA000_0000});
        repeat (17) tick('0, 0, 0);

        // Resend repeats A, then queued B follows with its own sequence.
        tick(mk(3, 1, 0, 32'hC0DE_0001), 0, 0);
        tick(mk(3, 1, 0, 32'hC0DE_0002), 0, 0);
        tick('0, 1, 0);
        @(negedge clk);
        chk("emit_A", dout, {1'b1, 5'd7, 4'd2, 7'd18, 32'hC0DE_0001});
        tick('0, 0, 0);
        @(negedge clk);
        chk("resend_A", dout, {1'b1, 5'd7, 4'd2, 7'd18, 32'hC0DE_0001});
        tick('0, 0, 0);
        @(negedge clk);
        chk("emit_B", dout, {1'b1, 5'd7, 4'd2, 7'd19, 32'hC0DE_0002});

        // Port2 -> leaf 9, port 5; 130 packets wrap its sequence, interleaved with port1.
        tick(mk(3, 0, 2, 32'h0000_0295), 0, 0);
        for (int i = 0; i < 130; i++) begin
            tick(mk(3, 2, 0, 32'(i)), 0, 0);
            if (i % 3 == 1) tick(mk(3, 1, 0, 32'h5000_0000 + i), 0, 0);
        end
        repeat (4) tick('0, 0, 0);
        tick('0, 1, 0);
        tick('0, 0, 0);
        @(negedge clk);
        chk("seq_wrap_resend", dout, {1'b1, 5'd9, 4'd5, 7'd1, 32'd129});
        chk("model_seq2", 49'(m_seq[2]), 49'd2);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            rp = {($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 7) < 6) ? 5'd3 : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 3)),
                  7'($urandom_range(0, 3)),
                  32'($urandom)};
            rp[9] = ($urandom_range(0, 3) != 0);
            tick(rp, ($urandom_range(0, 7) == 0), 0);
        end

        // Reset with packets queued discards them.
        tick(mk(3, 0, 1, 32'h0000_0272), 0, 0);
        for (int i = 0; i < 5; i++) tick(mk(3, 1, 0, 32'hE000_0000 + i), 1, 0);
        tick('0, 1, 1);
        tick('0, 0, 0);
        @(negedge clk);
        chk("post_reset_dout", dout, 49'd0);
        chk("post_reset_drop", 49'(drop_count), 49'd0);
        repeat (3) tick('0, 0, 0);
        @(negedge clk);
        chk("post_reset_idle", dout, 49'd0);
        chk("post_reset_full", 49'(fifo_full), 49'd0);
        tick('0, 1, 0);
        tick('0, 0, 0);
        @(negedge clk);
        chk("post_reset_resend", dout, 49'd0);

        tick('0, 0, 0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/leaf_relay.md
Name: leaf_relay

Overview:
- Parametrised BFT leaf endpoint; successor to the empty per-leaf output-function shells.
- Sits directly on the leaf's BFT packet pair (din_leaf_bft2interface / dout_leaf_interface2bft).
- Accepts packets addressed to itself, buffers data packets in a FIFO, and re-emits each one to a runtime-configured destination (leaf, port) with a per-input-port sequence number.
- On resend, retransmits the last emitted packet.

Parameters:
- PACKET_BITS, 49, packet width; must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
- PAYLOAD_BITS, 32, payload width
- NUM_LEAF_BITS, 5, leaf address width
- NUM_PORT_BITS, 4, port field width
- NUM_ADDR_BITS, 7, addr/sequence field width
- NUM_IN_PORTS, 2, number of data input ports (ports 1..NUM_IN_PORTS); port 0 is the config port
- FIFO_DEPTH, 16, buffer entries; power of two, >=2
- SELF_LEAF, 3, this leaf's address

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- din_leaf_bft2interface  in  PACKET_BITS  packet from BFT
- dout_leaf_interface2bft  out  PACKET_BITS  packet to BFT, registered
- resend  in  1  one-cycle request to retransmit the last emitted packet
- drop_count  out  16  saturating count of discarded packets
- fifo_full  out  1  FIFO occupancy == FIFO_DEPTH

Behaviour:
- Packet fields, MSB to LSB: valid[48], leaf[47:43], port[42:39], addr[38:32], payload[31:0]. Generalise the offsets by parameter.
- Reset: dout=0, drop_count=0, fifo_full=0. FIFO emptied, route table cleared (all entries disabled), sequence counters=0, last_sent=0.
- Reset mid-operation discards all buffered packets; no packet is emitted on the cycle after reset deasserts.
- Accept rule: a packet is accepted when valid=1 and leaf==SELF_LEAF; all other packets are ignored and not counted.
- Config (port 0):
  - addr selects route entry p (1..NUM_IN_PORTS).
  - payload[8:0] = {dest_leaf[8:4], dest_port[3:0]}; payload[9] = enable.
  - Write takes effect at that edge.
  - p==0 or p>NUM_IN_PORTS: packet dropped and counted.
- Data (port 1..NUM_IN_PORTS): enqueue {port, payload} iff the entry is enabled and the FIFO is not full; otherwise increment drop_count.
- Data on port >NUM_IN_PORTS: dropped and counted.
- drop_count saturates at 0xFFFF.
- Full FIFO refuses writes even when a pop occurs in the same cycle. Push and pop in the same cycle are otherwise allowed.
- Output register, evaluated at every edge, in priority order:
  - (1) resend=1: dout <= last_sent; FIFO not popped; sequence unchanged. If nothing has been sent since reset, dout <= 0.
  - (2) FIFO non-empty: pop; dout <= {1, route[port].leaf, route[port].port, seq[port], payload}; last_sent <= same; seq[port]++ (wraps modulo 2^NUM_ADDR_BITS).
  - (3) otherwise dout <= 0.
- Route lookup happens at pop time, so a reconfiguration applies to packets already queued. If the entry was disabled after enqueue, the packet is still emitted with the stored destination bits of the current (disabled) entry.
- Latency: a packet presented in cycle t with the FIFO empty and no resend appears on dout in cycle t+2. Throughput is 1 packet/cycle.

Optional Feature:
- Macro: LEAF_RELAY_STATS_EN.
- Defined: adds output fwd_count (16 bits), which counts FIFO-sourced emissions (excludes resends), wraps at 2^16, and resets to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package leaf_relay_pkg holds:
  - field offset/width localparams;
  - route_entry_t {enable, dest_leaf, dest_port};
  - CFG_PORT=0 constant.
- One sub-module: leaf_relay_fifo, a synchronous FIFO with push/pop/full/empty and a count output. The top level holds the route table, sequence counters and output mux.

Test Plan:
- Config port1→(leaf 7, port 2, enable). Send data port1 payload 0xDEADBEEF → 2 cycles later dout = {1, 7, 2, addr 0, 0xDEADBEEF}. A second packet → addr 1.
- Data to port1 with no config → nothing emitted; drop_count=1. Packet with leaf=4 → ignored; drop_count stays 1.
- Fill 16 packets while the output is continuously stalled by resend=1 → fifo_full=1. 17th → drop_count+1. Release → 16 packets out in order, consecutive cycles.
- Emit packet A, pulse resend → A repeated next cycle. The queued packet B follows one cycle later with B's seq unchanged by the resend.
- Send 130 packets on port2 → addr field wraps 127→0. Interleave with port1 → independent sequences.
- Assert reset with 5 packets queued → dout=0 the following cycle. Nothing is emitted afterwards, and resend then outputs 0.
